// File: rtl/dispatch_buffer_pkg.sv
// Shared types for the dispatch buffer: decoded-instruction payload, lane counts and helpers.
package dispatch_buffer_pkg;

    typedef logic [31:0] word;

    typedef struct packed {
        word pc;
        word instr;
    } decode_struct;

    localparam int ISSUE_WIDTH = 2;

    typedef logic [1:0] lane_cnt_t;

    function automatic lane_cnt_t lane_popcount(input logic [0:1] v);
        return lane_cnt_t'(v[0]) + lane_cnt_t'(v[1]);
    endfunction

endpackage

// File: rtl/dispatch_buffer_ring_ptr.sv
// Circular queue pointer: advances by 0..2 per cycle and wraps modulo DEPTH (power of two).
module ring_ptr
    import dispatch_buffer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  lane_cnt_t                inc,
    output logic [$clog2(DEPTH)-1:0] ptr
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] ptr_reg;

    // Power-of-two depth lets the natural adder overflow provide the wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= '0;
        end else if (clr) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_reg + PW'(inc);
        end
    end

    assign ptr = ptr_reg;

endmodule

// File: rtl/dispatch_buffer.sv
// Two-wide in-order dispatch queue between DECODE and issue/rename.
// Optional same-cycle pass-through when empty: define DISPATCH_BYPASS_EN.
module dispatch_buffer
    import dispatch_buffer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_flush,
    input  logic [0:1]               i_valid,
    input  decode_struct [0:1]       i_decode_data,
    output logic                     o_ready,
    output logic [0:1]               o_valid,
    output decode_struct [0:1]       o_decode_data,
    input  lane_cnt_t                i_deq_cnt,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    decode_struct       storage [DEPTH];
    logic [PW-1:0]      head;
    logic [PW-1:0]      tail;
    logic [CW-1:0]      count_reg;
    logic [CW-1:0]      count_next;

    decode_struct [0:1] in_lane;
    lane_cnt_t          n_in;
    lane_cnt_t          avail;
    lane_cnt_t          n_deq;
    lane_cnt_t          skip;
    lane_cnt_t          n_enq;
    lane_cnt_t          head_inc;
    decode_struct [0:1] wr_data;
    logic [0:1]         wr_en;
    logic               bypass_active;

`ifdef DISPATCH_BYPASS_EN
    assign bypass_active = i_rst_n && (count_reg == '0) && !i_flush;
`else
    assign bypass_active = 1'b0;
`endif

    assign o_ready = (CW'(DEPTH) - count_reg) >= CW'(2);

    always_comb begin
        // Compact valid lanes so a lone lane-1 entry behaves like the oldest one.
        in_lane[0] = i_valid[0] ? i_decode_data[0] : i_decode_data[1];
        in_lane[1] = i_decode_data[1];
        n_in       = lane_popcount(i_valid);

        avail = (count_reg >= CW'(2)) ? 2'd2 : lane_cnt_t'(count_reg[0]);
        if (bypass_active) begin
            avail = n_in;
        end
        n_deq = (i_deq_cnt > avail) ? avail : i_deq_cnt;

        skip     = bypass_active ? n_deq : 2'd0;
        n_enq    = (o_ready && !i_flush) ? (n_in - skip) : 2'd0;
        head_inc = (i_flush || bypass_active) ? 2'd0 : n_deq;

        wr_data[0] = (skip == 2'd0) ? in_lane[0] : in_lane[1];
        wr_data[1] = in_lane[1];
        wr_en[0]   = n_enq != 2'd0;
        wr_en[1]   = n_enq == 2'd2;

        count_next = i_flush ? '0 : (count_reg + CW'(n_enq) - CW'(head_inc));
    end

    ring_ptr #(.DEPTH(DEPTH)) u_head (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .clr   (i_flush),
        .inc   (head_inc),
        .ptr   (head)
    );

    ring_ptr #(.DEPTH(DEPTH)) u_tail (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .clr   (i_flush),
        .inc   (n_enq),
        .ptr   (tail)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en[0]) storage[tail] <= wr_data[0];
        if (wr_en[1]) storage[tail + PW'(1)] <= wr_data[1];
    end

    genvar gi;
    generate
        for (gi = 0; gi < ISSUE_WIDTH; gi++) begin : g_out
            always_comb begin
                o_valid[gi]       = count_reg > CW'(gi);
                o_decode_data[gi] = storage[head + PW'(gi)];
                if (bypass_active) begin
                    o_valid[gi]       = n_in > lane_cnt_t'(gi);
                    o_decode_data[gi] = in_lane[gi];
                end
            end
        end
    endgenerate

    assign o_count = count_reg;

`ifndef SYNTHESIS
    a_no_drop: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        ((|i_valid) && !i_flush) |-> o_ready);
    a_deq_overrun: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !i_flush |-> (i_deq_cnt <= avail));
`endif

endmodule

// File: tb/tb_dispatch_buffer.sv
// Directed bench for dispatch_buffer (default build): queue model plus hand-computed checks.
module tb_dispatch_buffer;
    import dispatch_buffer_pkg::*;

    localparam int DEPTH = 8;

    logic               clk;
    logic               rst_n;
    logic               flush;
    logic [0:1]         valid;
    decode_struct [0:1] din;
    logic               ready;
    logic [0:1]         ovalid;
    decode_struct [0:1] dout;
    lane_cnt_t          deq_cnt;
    logic [3:0]         count;

    int                 vec_cnt;
    int                 miss_cnt;
    int                 seq;
    logic [63:0]        q [$];

    dispatch_buffer #(.DEPTH(DEPTH)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_flush       (flush),
        .i_valid       (valid),
        .i_decode_data (din),
        .o_ready       (ready),
        .o_valid       (ovalid),
        .o_decode_data (dout),
        .i_deq_cnt     (deq_cnt),
        .o_count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] mk(input int n);
        return {32'h0000_1000 + 32'(n * 4), 32'hA000_0000 + 32'(n)};
    endfunction

    task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        valid   = '0;
        deq_cnt = 2'd0;
        flush   = 1'b0;
    endtask

    // One clock of stimulus; the model is updated with what the queue should have accepted.
    task automatic step(input logic v0, input logic v1, input int deq, input logic fl);
        logic [63:0] d0;
        logic [63:0] d1;
        logic        en;
        d0 = mk(seq);
        d1 = mk(seq + 1);
        seq += 2;
        valid[0] = v0;
        valid[1] = v1;
        din[0]   = d0;
        din[1]   = d1;
        deq_cnt  = lane_cnt_t'(deq);
        flush    = fl;
        en       = (q.size() <= DEPTH - 2);
        @(posedge clk);
        #1;
        if (fl) begin
            q.delete();
        end else begin
            for (int i = 0; i < deq; i++) void'(q.pop_front());
            if (en && v0) q.push_back(d0);
            if (en && v1) q.push_back(d1);
        end
        set_idle();
        $display("step: valid=%b%b deq=%0d flush=%b -> count=%0d model=%0d",
                 v0, v1, deq, fl, count, q.size());
    endtask

    initial begin
        vec_cnt  = 0;
        miss_cnt = 0;
        seq      = 0;

        // Reset held with both lanes valid.
        rst_n    = 1'b0;
        flush    = 1'b0;
        deq_cnt  = 2'd0;
        valid[0] = 1'b1;
        valid[1] = 1'b1;
        din[0]   = mk(0);
        din[1]   = mk(1);
        seq      = 2;
        repeat (2) @(posedge clk);
        #1;
        check_vec("rst_valid", 64'(ovalid), 64'd0);
        check_vec("rst_count", 64'(count), 64'd0);
        check_vec("rst_ready", 64'(ready), 64'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        q.push_back(mk(0));
        q.push_back(mk(1));
        set_idle();
        check_vec("rel_count", 64'(count), 64'd2);
        check_vec("rel_v0", 64'(ovalid[0]), 64'd1);
        check_vec("rel_v1", 64'(ovalid[1]), 64'd1);
        check_vec("rel_d0", dout[0], mk(0));
        check_vec("rel_d1", dout[1], mk(1));

        // Fill to full with pairs.
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        check_vec("six_count", 64'(count), 64'd6);
        check_vec("six_ready", 64'(ready), 64'd1);
        step(1, 1, 0, 0);
        check_vec("full_count", 64'(count), 64'd8);
        check_vec("full_ready", 64'(ready), 64'd0);
        check_vec("full_d0", dout[0], q[0]);

        // Seven entries must still back-pressure.
        step(0, 0, 1, 0);
        check_vec("seven_count", 64'(count), 64'd7);
        check_vec("seven_ready", 64'(ready), 64'd0);
        check_vec("seven_d0", dout[0], mk(1));
        step(0, 0, 2, 0);
        step(0, 0, 2, 0);
        check_vec("three_count", 64'(count), 64'd3);

        // Simultaneous enqueue of two and dequeue of two.
        step(1, 1, 2, 0);
        check_vec("encdeq_count", 64'(count), 64'd3);
        check_vec("encdeq_d0", dout[0], mk(7));
        check_vec("encdeq_d1", dout[1], q[1]);

        // Drain, then single entry on lane 1 only.
        step(0, 0, 2, 0);
        step(0, 0, 1, 0);
        check_vec("empty_count", 64'(count), 64'd0);
        check_vec("empty_v0", 64'(ovalid[0]), 64'd0);
        step(0, 1, 0, 0);
        check_vec("lane1_count", 64'(count), 64'd1);
        check_vec("lane1_v0", 64'(ovalid[0]), 64'd1);
        check_vec("lane1_v1", 64'(ovalid[1]), 64'd0);
        check_vec("lane1_d0", dout[0], mk(seq - 1));
        step(0, 0, 1, 0);

        // Flush beats concurrent enqueue and dequeue.
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        check_vec("pre_flush_count", 64'(count), 64'd6);
        step(1, 1, 2, 1);
        check_vec("flush_count", 64'(count), 64'd0);
        check_vec("flush_v0", 64'(ovalid[0]), 64'd0);
        check_vec("flush_v1", 64'(ovalid[1]), 64'd0);
        check_vec("flush_ready", 64'(ready), 64'd1);

        // Stream pairs through so both pointers wrap several times.
        for (int k = 0; k < 20; k++) begin
            step(1, 1, (q.size() >= 2) ? 2 : q.size(), 0);
            check_vec("wrap_count", 64'(count), 64'd2);
            check_vec("wrap_d0", dout[0], q[0]);
            check_vec("wrap_d1", dout[1], q[1]);
        end
        step(0, 0, 2, 0);
        check_vec("final_count", 64'(count), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
